// File: rtl/c2h_packetizer.sv
// Frames DDR readback beats into S2MM packets: tlast on beat count, flush, or idle timeout (C2H_TIMEOUT_EN).
// Accept-to-tvalid is at least 2 cycles; rd_ready drops once fifo_count exceeds FIFO_DEPTH-2 and dropped beats set overflow.

// Generic FIFO whose head sits in an output register; a push into an empty FIFO lands there directly.
module c2h_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_vld,
  input  logic [W-1:0]           push_dat,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [W-1:0]           out_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] mem_cnt_q, mem_cnt_d;
  logic          out_vld_q, out_vld_d;
  logic [W-1:0]  out_dat_q, out_dat_d;
  logic          load_out, mem_rd, mem_wr;

  always_comb begin
    load_out  = !out_vld_q || out_rdy;
    mem_rd    = load_out && (mem_cnt_q != '0);
    mem_wr    = push_vld && !(load_out && (mem_cnt_q == '0));
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    if (load_out) begin
      if (mem_rd) begin
        out_vld_d = 1'b1;
        out_dat_d = mem[rd_ptr_q];
      end else if (push_vld) begin
        out_vld_d = 1'b1;
        out_dat_d = push_dat;
      end else begin
        out_vld_d = 1'b0;
      end
    end
    wr_ptr_d  = wr_ptr_q + AW'(mem_wr);
    rd_ptr_d  = rd_ptr_q + AW'(mem_rd);
    mem_cnt_d = mem_cnt_q + CW'(mem_wr) - CW'(mem_rd);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_cnt_q <= mem_cnt_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr_q] <= push_dat;
  end

  assign out_vld = out_vld_q;
  assign out_dat = out_dat_q;
  assign count   = mem_cnt_q + CW'(out_vld_q);
endmodule

module c2h_packetizer #(
  parameter int DATA_WIDTH     = 512,
  parameter int FIFO_DEPTH     = 64,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          c0_ddr4_clk,
  input  logic                          axi_resetn,
  input  logic [DATA_WIDTH-1:0]         rd_data,
  input  logic                          rd_valid,
  output logic                          rd_ready,
  input  logic                          flush,
  input  logic [CNT_WIDTH-1:0]          pkt_beats_cfg,
  output logic [DATA_WIDTH-1:0]         M_AXIS_C2H_tdata,
  output logic [DATA_WIDTH/8-1:0]       M_AXIS_C2H_tkeep,
  output logic                          M_AXIS_C2H_tlast,
  output logic                          M_AXIS_C2H_tvalid,
  input  logic                          M_AXIS_C2H_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_WIDTH-1:0]          pkt_count,
  output logic                          overflow
);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] dat;
  } beat_t;

  logic                 rdy_en_q, rdy_en_d;
  logic                 stg_vld_q, stg_vld_d;
  beat_t                stg_q, stg_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
  logic                 overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0] cfg_len, cur_len;
  logic                 accept, flush_push, push, tmo, ld_last;
  beat_t                push_beat, out_beat;

  assign rd_ready = rdy_en_q && (fifo_count <= FCW'(FIFO_DEPTH - 2));
  assign accept   = rd_valid && rd_ready;

`ifdef C2H_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle_q, idle_d;

  always_comb begin
    idle_d = idle_q;
    if (accept || push) idle_d = '0;
    else if (stg_vld_q) idle_d = idle_q + IW'(1);
  end

  always_ff @(posedge c0_ddr4_clk) begin
    if (!axi_resetn) idle_q <= '0;
    else             idle_q <= idle_d;
  end

  assign tmo = stg_vld_q && !accept && (idle_q == IW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    flush_push     = flush && stg_vld_q && !accept;
    push           = stg_vld_q && (accept || stg_q.last || flush_push || tmo);
    push_beat      = stg_q;
    push_beat.last = stg_q.last || flush_push || tmo;
    cfg_len        = (pkt_beats_cfg == '0) ? CNT_WIDTH'(1) : pkt_beats_cfg;
    // Length is sampled only when a packet opens; later cfg changes wait for the next packet.
    cur_len        = (beat_cnt_q == '0) ? cfg_len : len_q;
    ld_last        = (beat_cnt_q == cur_len - CNT_WIDTH'(1)) || flush;

    rdy_en_d   = 1'b1;
    stg_vld_d  = stg_vld_q;
    stg_d      = stg_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    if (accept) begin
      stg_vld_d  = 1'b1;
      stg_d.dat  = rd_data;
      stg_d.last = ld_last;
      len_d      = cur_len;
      beat_cnt_d = ld_last ? '0 : beat_cnt_q + CNT_WIDTH'(1);
    end else if (push) begin
      stg_vld_d  = 1'b0;
      beat_cnt_d = '0;
    end

    pkt_count_d = pkt_count_q
                + CNT_WIDTH'(M_AXIS_C2H_tvalid && M_AXIS_C2H_tready && M_AXIS_C2H_tlast);
    overflow_d  = overflow_q || (rd_valid && !rd_ready);
  end

  always_ff @(posedge c0_ddr4_clk) begin
    if (!axi_resetn) begin
      rdy_en_q    <= 1'b0;
      stg_vld_q   <= 1'b0;
      stg_q       <= '0;
      beat_cnt_q  <= '0;
      len_q       <= '0;
      pkt_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      rdy_en_q    <= rdy_en_d;
      stg_vld_q   <= stg_vld_d;
      stg_q       <= stg_d;
      beat_cnt_q  <= beat_cnt_d;
      len_q       <= len_d;
      pkt_count_q <= pkt_count_d;
      overflow_q  <= overflow_d;
    end
  end

  c2h_fifo #(
    .W     ($bits(beat_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (c0_ddr4_clk),
    .rst_n    (axi_resetn),
    .push_vld (push),
    .push_dat (push_beat),
    .out_vld  (M_AXIS_C2H_tvalid),
    .out_rdy  (M_AXIS_C2H_tready),
    .out_dat  (out_beat),
    .count    (fifo_count)
  );

  assign M_AXIS_C2H_tdata = out_beat.dat;
  assign M_AXIS_C2H_tlast = out_beat.last;
  assign M_AXIS_C2H_tkeep = '1;
  assign pkt_count        = pkt_count_q;
  assign overflow         = overflow_q;
endmodule

// File: tb/tb_c2h_packetizer.sv
// Directed bench for c2h_packetizer: stimulus queues expected beats, a monitor pops and compares on each stream handshake.
`timescale 1ns/1ps
module tb_c2h_packetizer;
  localparam int DW  = 512;
  localparam int KW  = DW / 8;
  localparam int CW  = 16;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          axi_resetn;
  logic [DW-1:0] rd_data;
  logic          rd_valid, rd_ready, flush;
  logic [CW-1:0] pkt_beats_cfg;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tlast, tvalid, tready;
  logic [6:0]    fifo_count;
  logic [CW-1:0] pkt_count;
  logic          overflow;

  typedef struct {
    int   tag;
    logic last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;
  int   exp_pkts = 0;
  int   cyc = 0;
  int   last_pop_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  c2h_packetizer #(.TIMEOUT_CYCLES(TMO)) dut (
    .c0_ddr4_clk       (clk),
    .axi_resetn        (axi_resetn),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .rd_ready          (rd_ready),
    .flush             (flush),
    .pkt_beats_cfg     (pkt_beats_cfg),
    .M_AXIS_C2H_tdata  (tdata),
    .M_AXIS_C2H_tkeep  (tkeep),
    .M_AXIS_C2H_tlast  (tlast),
    .M_AXIS_C2H_tvalid (tvalid),
    .M_AXIS_C2H_tready (tready),
    .fifo_count        (fifo_count),
    .pkt_count         (pkt_count),
    .overflow          (overflow)
  );

  function automatic logic [DW-1:0] pat(input int tag);
    logic [31:0] t;
    t = tag;
    return {16{t}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input int tag, input logic last);
    exp_t e;
    e.tag  = tag;
    e.last = last;
    sb.push_back(e);
    if (last) exp_pkts++;
  endtask

  task automatic send(input int tag, input logic fl, input logic exp_last, input logic expect_it);
    rd_valid = 1'b1;
    rd_data  = pat(tag);
    flush    = fl;
    if (expect_it) expect_beat(tag, exp_last);
    tick();
    rd_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || tvalid) && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, 64'(sb.size() == 0 && !tvalid), 64'd1);
  endtask

  // Scoreboard monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (axi_resetn && tvalid && tready) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_beat: got tag 0x%08h, expected no beat", tdata[31:0]);
      end else begin
        mon_e = sb.pop_front();
        n_chk++;
        if (tdata === pat(mon_e.tag)) n_pass++;
        else $display("FAIL tdata: got 0x%08h, expected 0x%08h", tdata[31:0], mon_e.tag);
        chk("tlast", 64'(tlast), 64'(mon_e.last));
        chk("tkeep", 64'(tkeep), 64'hFFFF_FFFF_FFFF_FFFF);
        last_pop_cyc = cyc;
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n_acc;
    int fall_cnt;
    int acc_cyc;

    axi_resetn    = 1'b0;
    rd_valid      = 1'b0;
    rd_data       = '0;
    flush         = 1'b0;
    pkt_beats_cfg = 16'd4;
    tready        = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_ready",   64'(rd_ready),   64'd0);
    chk("rst_tvalid",     64'(tvalid),     64'd0);
    chk("rst_tlast",      64'(tlast),      64'd0);
    chk("rst_tdata_zero", 64'(tdata == '0), 64'd1);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_pkt_count",  64'(pkt_count),  64'd0);
    chk("rst_overflow",   64'(overflow),   64'd0);
    tick();
    axi_resetn = 1'b1;
    tick();
    chk("rd_ready_after_release", 64'(rd_ready), 64'd1);

    // Two full 4-beat packets.
    tready = 1'b1;
    for (int i = 1; i <= 8; i++) send(i, 1'b0, (i % 4) == 0, 1'b1);
    drain("t1", 40);
    chk("t1_pkt_count",  64'(pkt_count),  64'(exp_pkts));
    chk("t1_fifo_count", 64'(fifo_count), 64'd0);
    chk("t1_overflow",   64'(overflow),   64'd0);

    // Short packet closed by a flush two cycles after the last beat.
    for (int i = 11; i <= 13; i++) send(i, 1'b0, i == 13, 1'b1);
    tick();
    pulse_flush();
    drain("t2", 40);
    chk("t2_pkt_count", 64'(pkt_count), 64'(exp_pkts));

    // Flush on an empty stage, then a flush with a single beat.
    pulse_flush();
    tick();
    send(21, 1'b1, 1'b1, 1'b1);
    drain("t3", 40);
    repeat (4) tick();
    chk("t3_no_empty_pkt", 64'(tvalid), 64'd0);
    chk("t3_pkt_count",    64'(pkt_count), 64'(exp_pkts));

    // Back-pressure: 70 beats into a stalled stream; 64 fit (63 in FIFO plus the stage).
    tready   = 1'b0;
    n_acc    = 0;
    fall_cnt = -1;
    for (int i = 0; i < 70; i++) begin
      rd_valid = 1'b1;
      rd_data  = pat(100 + i);
      if (i < 64) expect_beat(100 + i, (i % 4) == 3);
      @(negedge clk);
      if (rd_ready) n_acc++;
      else if (fall_cnt < 0) fall_cnt = int'(fifo_count);
      tick();
    end
    rd_valid = 1'b0;
    tick();
    tick();
    chk("t4_accepted",         64'(n_acc),      64'd64);
    chk("t4_ready_fall_count", 64'(fall_cnt),   64'd63);
    chk("t4_fifo_full",        64'(fifo_count), 64'd64);
    chk("t4_rd_ready_low",     64'(rd_ready),   64'd0);
    chk("t4_overflow",         64'(overflow),   64'd1);
    tready = 1'b1;
    drain("t4", 200);
    chk("t4_pkt_count",       64'(pkt_count), 64'(exp_pkts));
    chk("t4_overflow_sticky", 64'(overflow),  64'd1);

    // Trailing short packet: 5 beats of an 8-beat packet, then idle.
    pkt_beats_cfg = 16'd8;
    for (int i = 0; i < 5; i++) send(200 + i, 1'b0, i == 4, 1'b1);
    acc_cyc = cyc;
`ifdef C2H_TIMEOUT_EN
    repeat (10) tick();
    chk("t5_not_early", 64'(sb.size()), 64'd1);
    drain("t5", 30);
    chk("t5_timeout_window",
        64'((last_pop_cyc - acc_cyc) >= 15 && (last_pop_cyc - acc_cyc) <= 18), 64'd1);
`else
    repeat (40) tick();
    chk("t5_held_without_timeout", 64'(sb.size()), 64'd1);
    pulse_flush();
    drain("t5", 40);
`endif
    chk("t5_pkt_count", 64'(pkt_count), 64'(exp_pkts));

    // One-cycle reset while a beat is held at the output; those beats are discarded.
    pkt_beats_cfg = 16'd4;
    tready = 1'b0;
    send(300, 1'b0, 1'b0, 1'b0);
    send(301, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    chk("t6_held_tvalid", 64'(tvalid), 64'd1);
    axi_resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_tvalid",     64'(tvalid),     64'd0);
    chk("t6_rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("t6_rst_pkt_count",  64'(pkt_count),  64'd0);
    chk("t6_rst_overflow",   64'(overflow),   64'd0);
    chk("t6_rst_rd_ready",   64'(rd_ready),   64'd0);
    axi_resetn = 1'b1;
    exp_pkts   = 0;
    tick();
    chk("t6_rd_ready_release", 64'(rd_ready), 64'd1);
    tready = 1'b1;
    for (int i = 0; i < 4; i++) send(400 + i, 1'b0, i == 3, 1'b1);
    drain("t6", 40);
    chk("t6_pkt_count", 64'(pkt_count), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
